// File: rtl/simon_pkg.sv
// Shared types for the Simon Says core: colour encoding and sequencer state.
package simon_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        StIdle,
        StAppend,
        StShowOn,
        StShowGap,
        StInput
    } seq_state_t;

endpackage

// File: rtl/seq_mem.sv
// Colour sequence store: synchronous write, combinational read, no reset.
module seq_mem
    import simon_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  color_t           wdata,
    input  logic [AddrW-1:0] raddr,
    output color_t           rdata
);

    color_t mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Look-ahead reads past the last entry are harmless but must stay in range.
    assign rdata = (32'(raddr) < Depth) ? mem[raddr] : RED;

endmodule

// File: rtl/simon_sequencer.sv
// Simon game engine: grows the colour sequence, replays it on the LEDs and checks
// the player's presses in order.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned SHOW_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   random_seq,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_color,
    output logic                         led_valid,
    output logic [1:0]                   led_color,
    output logic                         awaiting_input,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         round_pass,
    output logic                         game_over,
    output logic                         game_win
);

    localparam int unsigned LW   = $clog2(MAX_LEN + 1);
    localparam int unsigned AW   = $clog2(MAX_LEN);
    localparam int unsigned TMax = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMax + 1);

    localparam logic [TW-1:0] ShowLast = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GapLast  = TW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] MaxLen   = LW'(MAX_LEN);

    seq_state_t    state_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [TW-1:0] tmr_q;

    logic [AW-1:0] raddr;
    color_t        rdata;
    color_t        led_next;
    logic          last;

    assign last  = (idx_q == len_q - LW'(1));
    assign level = len_q;

    // The gap state pre-fetches the next colour so the LED register loads it on entry.
    always_comb begin
        raddr = AW'(idx_q);
        if (state_q == StShowGap) begin
            raddr = AW'(idx_q + LW'(1));
        end else if (state_q == StAppend) begin
            raddr = '0;
        end
    end

    // First round: entry 0 is being written this very cycle, so bypass the memory.
    assign led_next = (len_q == '0) ? color_t'(random_seq) : rdata;

    seq_mem #(
        .Depth (MAX_LEN),
        .AddrW (AW)
    ) u_seq_mem (
        .clk   (clk),
        .we    (state_q == StAppend),
        .waddr (AW'(len_q)),
        .wdata (color_t'(random_seq)),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            len_q          <= '0;
            idx_q          <= '0;
            tmr_q          <= '0;
            led_valid      <= 1'b0;
            led_color      <= 2'b00;
            awaiting_input <= 1'b0;
            round_pass     <= 1'b0;
            game_over      <= 1'b0;
            game_win       <= 1'b0;
        end else begin
            round_pass <= 1'b0;
            game_over  <= 1'b0;
            game_win   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q   <= '0;
                        state_q <= StAppend;
                    end
                end
                StAppend: begin
                    len_q     <= len_q + LW'(1);
                    idx_q     <= '0;
                    tmr_q     <= '0;
                    led_valid <= 1'b1;
                    led_color <= led_next;
                    state_q   <= StShowOn;
                end
                StShowOn: begin
                    if (tmr_q == ShowLast) begin
                        tmr_q     <= '0;
                        led_valid <= 1'b0;
                        led_color <= 2'b00;
                        state_q   <= StShowGap;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                StShowGap: begin
                    if (tmr_q == GapLast) begin
                        tmr_q <= '0;
                        if (last) begin
                            idx_q          <= '0;
                            awaiting_input <= 1'b1;
                            state_q        <= StInput;
                        end else begin
                            idx_q     <= idx_q + LW'(1);
                            led_valid <= 1'b1;
                            led_color <= rdata;
                            state_q   <= StShowOn;
                        end
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                StInput: begin
                    if (btn_valid) begin
                        if (btn_color != rdata) begin
                            game_over      <= 1'b1;
                            awaiting_input <= 1'b0;
                            state_q        <= StIdle;
                        end else if (!last) begin
                            idx_q <= idx_q + LW'(1);
                        end else if (len_q == MaxLen) begin
                            game_win       <= 1'b1;
                            awaiting_input <= 1'b0;
                            state_q        <= StIdle;
                        end else begin
                            round_pass     <= 1'b1;
                            awaiting_input <= 1'b0;
                            state_q        <= StAppend;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Randomised bench for simon_sequencer against a queue-based model of the game rules.
module tb_simon_sequencer;

    localparam int unsigned MaxLen = 4;
    localparam int unsigned Show   = 8;
    localparam int unsigned Gap    = 4;
    localparam int unsigned LW     = $clog2(MaxLen + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    random_seq;
    logic          btn_valid;
    logic [1:0]    btn_color;
    logic          led_valid;
    logic [1:0]    led_color;
    logic          awaiting_input;
    logic [LW-1:0] level;
    logic          round_pass;
    logic          game_over;
    logic          game_win;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] model_seq [$];

    always #5 clk = ~clk;

    simon_sequencer #(
        .MAX_LEN     (MaxLen),
        .SHOW_CYCLES (Show),
        .GAP_CYCLES  (Gap)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .random_seq     (random_seq),
        .btn_valid      (btn_valid),
        .btn_color      (btn_color),
        .led_valid      (led_valid),
        .led_color      (led_color),
        .awaiting_input (awaiting_input),
        .level          (level),
        .round_pass     (round_pass),
        .game_over      (game_over),
        .game_win       (game_win)
    );

    task automatic abort_game();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called from IDLE; returns at the first lit cycle of round 1.
    task automatic start_game(input logic [1:0] c);
        start      = 1'b1;
        random_seq = c;
        @(negedge clk);
        start = 1'b0;
        model_seq.delete();
        model_seq.push_back(c);
        n_checks++;
        if ({led_valid, awaiting_input, round_pass, game_over, game_win} !== 5'b0 ||
            level !== LW'(0)) begin
            n_fail++;
            $display("FAIL append_cycle: level=%0d led_valid=%b awaiting=%b, want level=0 all low",
                     level, led_valid, awaiting_input);
        end
        @(negedge clk);
    endtask

    // Checks the whole replay of model_seq; returns at the first INPUT cycle.
    task automatic playback(input bit noise);
        int on_ok;
        int off_ok;
        n_checks++;
        if (level !== LW'(model_seq.size())) begin
            n_fail++;
            $display("FAIL level_at_show: got %0d want %0d", level, model_seq.size());
        end
        for (int i = 0; i < model_seq.size(); i++) begin
            on_ok  = 0;
            off_ok = 0;
            repeat (Show) begin
                if (led_valid === 1'b1 && led_color === model_seq[i] && awaiting_input === 1'b0 &&
                    {round_pass, game_over, game_win} === 3'b0) on_ok++;
                if (noise) begin
                    btn_valid = 1'($urandom % 2);
                    btn_color = 2'($urandom % 4);
                end
                @(negedge clk);
            end
            repeat (Gap) begin
                if (led_valid === 1'b0 && led_color === 2'b00 && awaiting_input === 1'b0 &&
                    {round_pass, game_over, game_win} === 3'b0) off_ok++;
                if (noise) begin
                    btn_valid = 1'($urandom % 2);
                    btn_color = 2'($urandom % 4);
                end
                @(negedge clk);
            end
            n_checks++;
            if (on_ok != Show || off_ok != Gap) begin
                n_fail++;
                $display("FAIL show_colour[%0d]: lit-ok %0d dark-ok %0d cycles, want %0d and %0d",
                         i, on_ok, off_ok, Show, Gap);
            end
        end
        btn_valid = 1'b0;
        n_checks++;
        if (awaiting_input !== 1'b1 || led_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_input: awaiting=%b led_valid=%b, want 1 and 0",
                     awaiting_input, led_valid);
        end
    endtask

    // Enters the whole sequence correctly; next_c is the colour for the following round.
    task automatic answer_round(input bit b2b, input bit extra, input logic [1:0] next_c);
        int bad = 0;
        bit win = (model_seq.size() == MaxLen);
        random_seq = next_c;
        for (int i = 0; i < model_seq.size(); i++) begin
            btn_valid = 1'b1;
            btn_color = model_seq[i];
            @(negedge clk);
            if (i != model_seq.size() - 1) begin
                if (awaiting_input !== 1'b1 || {round_pass, game_over, game_win} !== 3'b0) bad++;
                if (!b2b) begin
                    btn_valid = 1'b0;
                    @(negedge clk);
                    if (awaiting_input !== 1'b1 || {round_pass, game_over, game_win} !== 3'b0)
                        bad++;
                end
            end
        end
        if (extra) begin
            btn_valid = 1'b1;
            btn_color = 2'($urandom % 4);
        end else begin
            btn_valid = 1'b0;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_round_presses: %0d bad cycles, want 0", bad);
        end
        n_checks++;
        if (round_pass !== !win || game_win !== win || game_over !== 1'b0 ||
            awaiting_input !== 1'b0 || level !== LW'(model_seq.size())) begin
            n_fail++;
            $display("FAIL round_end: pass=%b win=%b over=%b await=%b level=%0d, want %b %b 0 0 %0d",
                     round_pass, game_win, game_over, awaiting_input, level, !win, win,
                     model_seq.size());
        end
        @(negedge clk);
        btn_valid = 1'b0;
        n_checks++;
        if ({round_pass, game_over, game_win} !== 3'b0) begin
            n_fail++;
            $display("FAIL pulse_width: pulses=%b one cycle later, want 000",
                     {round_pass, game_over, game_win});
        end
        if (win) begin
            int lit = 0;
            repeat (Show + Gap) begin
                if (led_valid !== 1'b0 || awaiting_input !== 1'b0) lit++;
                @(negedge clk);
            end
            n_checks++;
            if (lit != 0 || level !== LW'(MaxLen)) begin
                n_fail++;
                $display("FAIL no_append_after_win: %0d active cycles level=%0d, want 0 and %0d",
                         lit, level, MaxLen);
            end
        end else begin
            model_seq.push_back(next_c);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        start      = 1'b0;
        btn_valid  = 1'b0;
        btn_color  = 2'b00;
        random_seq = 2'b00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({led_valid, led_color, awaiting_input, round_pass, game_over, game_win} !== 8'b0 ||
            level !== LW'(0)) begin
            n_fail++;
            $display("FAIL reset_state: led=%b/%0d await=%b level=%0d, want all 0",
                     led_valid, led_color, awaiting_input, level);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({led_valid, awaiting_input, round_pass, game_over, game_win} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: led=%b await=%b, want 0", led_valid, awaiting_input);
        end
    endtask

    task automatic test_round_1_2();
        start_game(2'd2);
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'd1);
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'($urandom % 4));
        abort_game();
    endtask

    task automatic test_wrong_press();
        start_game(2'd3);
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'd0);
        playback(1'b0);
        btn_valid = 1'b1;
        btn_color = 2'd3;
        @(negedge clk);
        n_checks++;
        if (game_over !== 1'b0 || awaiting_input !== 1'b1) begin
            n_fail++;
            $display("FAIL first_press_ok: over=%b await=%b, want 0 1", game_over, awaiting_input);
        end
        btn_color = 2'd1;
        @(negedge clk);
        btn_color = 2'd0;  // a press right after game over falls into IDLE
        n_checks++;
        if (game_over !== 1'b1 || round_pass !== 1'b0 || awaiting_input !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_press: over=%b pass=%b await=%b, want 1 0 0",
                     game_over, round_pass, awaiting_input);
        end
        @(negedge clk);
        btn_valid = 1'b0;
        n_checks++;
        if (game_over !== 1'b0 || level !== LW'(2) || led_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL level_hold: over=%b level=%0d led=%b, want 0 2 0",
                     game_over, level, led_valid);
        end
    endtask

    task automatic test_idle_ignored();
        int bad = 0;
        logic [1:0] c = 2'($urandom % 4);
        repeat (4) begin
            btn_valid = 1'b1;
            btn_color = 2'($urandom % 4);
            @(negedge clk);
            if ({round_pass, game_over, game_win, awaiting_input, led_valid} !== 5'b0 ||
                level !== LW'(2)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_presses: %0d bad cycles, want 0", bad);
        end
        start      = 1'b1;
        random_seq = c;
        btn_color  = 2'($urandom % 4);
        @(negedge clk);
        start     = 1'b0;
        btn_valid = 1'b0;
        n_checks++;
        if ({round_pass, game_over, game_win} !== 3'b0 || level !== LW'(0)) begin
            n_fail++;
            $display("FAIL start_wins: pulses=%b level=%0d, want 000 and 0",
                     {round_pass, game_over, game_win}, level);
        end
        model_seq.delete();
        model_seq.push_back(c);
        @(negedge clk);
        playback(1'b1);
        answer_round(1'b0, 1'b0, 2'($urandom % 4));
        playback(1'b1);
        answer_round(1'b1, 1'b0, 2'($urandom % 4));
        abort_game();
    endtask

    task automatic test_back_to_back();
        start_game(2'($urandom % 4));
        playback(1'b0);
        answer_round(1'b1, 1'b0, 2'($urandom % 4));
        playback(1'b0);
        answer_round(1'b1, 1'b0, 2'($urandom % 4));
        playback(1'b0);
        answer_round(1'b1, 1'b1, 2'($urandom % 4));
        playback(1'b0);
        abort_game();
    endtask

    task automatic test_win();
        start_game(2'd0);
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'd1);
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'd2);
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'd3);
        playback(1'b0);
        answer_round(1'b0, 1'b1, 2'($urandom % 4));
    endtask

    task automatic test_reset_mid_playback();
        start_game(2'($urandom % 4));
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'($urandom % 4));
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'($urandom % 4));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({led_valid, led_color, awaiting_input, round_pass, game_over, game_win} !== 8'b0 ||
            level !== LW'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_show: led=%b/%0d await=%b level=%0d, want all 0",
                     led_valid, led_color, awaiting_input, level);
        end
        rst = 1'b1;
        @(negedge clk);
        start_game(2'($urandom % 4));
        n_checks++;
        if (level !== LW'(1) || led_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_level: level=%0d led=%b, want 1 1", level, led_valid);
        end
        playback(1'b0);
        answer_round(1'b0, 1'b0, 2'($urandom % 4));
        abort_game();
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 6; g++) begin
            bit done = 1'b0;
            int rounds = 0;
            start_game(2'($urandom % 4));
            while (!done && rounds < MaxLen) begin
                rounds++;
                playback(1'($urandom % 2));
                if ($urandom % 4 == 0) begin
                    int p = $urandom_range(0, model_seq.size() - 1);
                    for (int i = 0; i < p; i++) begin
                        btn_valid = 1'b1;
                        btn_color = model_seq[i];
                        @(negedge clk);
                        btn_valid = 1'b0;
                        @(negedge clk);
                    end
                    btn_valid = 1'b1;
                    btn_color = model_seq[p] ^ 2'(1 + $urandom % 3);
                    @(negedge clk);
                    btn_valid = 1'b0;
                    n_checks++;
                    if (game_over !== 1'b1 || round_pass !== 1'b0 ||
                        level !== LW'(model_seq.size())) begin
                        n_fail++;
                        $display("FAIL rand_wrong[%0d]: over=%b pass=%b level=%0d, want 1 0 %0d",
                                 p, game_over, round_pass, level, model_seq.size());
                    end
                    @(negedge clk);
                    done = 1'b1;
                end else begin
                    done = (model_seq.size() == MaxLen);
                    answer_round(1'($urandom % 2), 1'($urandom % 2), 2'($urandom % 4));
                end
            end
            if (!done) abort_game();
        end
    endtask

    initial begin
        test_reset();
        test_round_1_2();
        test_wrong_press();
        test_idle_ignored();
        test_back_to_back();
        test_win();
        test_reset_mid_playback();
        test_random_games();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game-sequence engine for the Simon Says core, and the consumer of the 2-bit `random_seq` stream produced by `Random`. Each round it samples one new colour from `random_seq`, appends it to an internal sequence memory, and replays the whole sequence to the LED driver. It then accepts the player's button presses and checks them in order. It reports round pass, game over (wrong press) or win (`MAX_LEN` colours recalled).

## Interface
Parameters:
- `MAX_LEN`, 16: maximum sequence length; reaching it wins the game. Range 2..256.
- `SHOW_CYCLES`, 8: cycles each colour is lit during playback (≥1).
- `GAP_CYCLES`, 4: dark cycles after each lit colour (≥1).

Ports:
- `clk`  in  1  single clock. All state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `start`  in  1  level; sampled only in IDLE; begins a new game.
- `random_seq`  in  2  colour from `Random`; sampled only in APPEND.
- `btn_valid`  in  1  one-cycle pulse per player press.
- `btn_color`  in  2  colour of the press; qualified by `btn_valid`.
- `led_valid`  out  1  LED lit during playback.
- `led_color`  out  2  colour to light; 0 whenever `led_valid`=0.
- `awaiting_input`  out  1  high in INPUT.
- `level`  out  `$clog2(MAX_LEN+1)`  current sequence length.
- `round_pass`  out  1  one-cycle pulse when a round is completed correctly.
- `game_over`  out  1  one-cycle pulse on a wrong press.
- `game_win`  out  1  one-cycle pulse when round `MAX_LEN` is completed.

## Operation
- **Storage:** memory `mem[MAX_LEN]` of 2-bit entries, plus a length counter `len`, an index `idx` and a phase timer `tmr`.
- **IDLE:** all outputs at reset values. When `start`=1: set `len`=0, go to APPEND.
- **APPEND (1 cycle):** `mem[len]`←`random_seq`, `len`←`len`+1, `idx`←0, `tmr`←0, go to SHOW_ON.
- **SHOW_ON:** `led_valid`=1, `led_color`=`mem[idx]`. After `SHOW_CYCLES` cycles, go to SHOW_GAP with `tmr`←0.
- **SHOW_GAP:** `led_valid`=0. After `GAP_CYCLES` cycles:
  - if `idx`=`len`−1: go to INPUT with `idx`←0;
  - otherwise `idx`←`idx`+1 and go to SHOW_ON.
- **INPUT:** `awaiting_input`=1. On `btn_valid`:
  - `btn_color`≠`mem[idx]`: pulse `game_over`, go to IDLE.
  - Match and `idx`<`len`−1: `idx`←`idx`+1.
  - Match and `idx`=`len`−1 and `len`<`MAX_LEN`: pulse `round_pass`, go to APPEND.
  - Match and `idx`=`len`−1 and `len`=`MAX_LEN`: pulse `game_win`, go to IDLE.
- **Ignored inputs:** `btn_valid` outside INPUT; `start` outside IDLE.
- **`level`:** equals `len`. It holds after `game_over`/`game_win` and clears only on the next `start`.
- **Reset (any state, mid-playback or mid-input):** state←IDLE; `len`, `idx`, `tmr` and all outputs←0. Memory contents need not reset.

## Timing
- Outputs are registered. Each pulse is high for exactly the cycle after the edge that sampled the triggering `btn_valid`.
- `start` sampled high at edge N:
  - APPEND occupies cycle N+1;
  - `led_valid` rises at N+2.
- **Playback duration** per round: `len`×(`SHOW_CYCLES`+`GAP_CYCLES`) cycles. `awaiting_input` rises the cycle after the last gap ends.
- **Round turnaround:** the `round_pass` pulse cycle is the APPEND cycle. The first LED of the next playback follows one cycle later.
- **Back-to-back presses:** presses on consecutive cycles are each evaluated.
- **Final press:** a press on the same edge that ends INPUT is consumed. A press in the following cycle is ignored.
- **Simultaneous `start` and `btn_valid` in IDLE:** `start` wins; the button is ignored.

## Structure
- Package `simon_pkg`:
  - `color_t` (2-bit enum: RED=0, GREEN=1, BLUE=2, YELLOW=3);
  - state enum `seq_state_t`.
  - `Random` and future blocks share this package.
- One sub-module, `seq_mem`: a `MAX_LEN`×2 register file with a synchronous write port and a combinational read port.
- The FSM, counters and timer are in the top module.

## Test plan
- **Reset mid-playback:** assert `rst`=0 during SHOW_ON of round 3 → next cycle all outputs 0 and `level`=0. `start` then restarts from `level`=1.
- **Round 1 and 2:** `random_seq`=2 in APPEND → LED shows colour 2 for 8 cycles, then dark for 4, then `awaiting_input`. Press 2 → `round_pass` pulse. `random_seq`=1 → playback 2,1; presses 2,1 → `round_pass`, `level`=2.
- **Wrong press:** after sequence 3,0 is shown, press 3 then 1 → `game_over` pulse on the second press, state IDLE, `level` stays 2.
- **Win with `MAX_LEN`=4:** colours 0,1,2,3, all rounds answered correctly → three `round_pass` pulses, then one `game_win` on the fourth round's last press, no further APPEND.
- **Ignored presses:** `btn_valid` pulses during SHOW_ON/SHOW_GAP and in IDLE → no pulses and no change to `idx`. The subsequent correct input still passes.
- **Back-to-back presses:** correct presses on consecutive cycles for `len`=3 → `round_pass` exactly one cycle after the third press.
